vga_fb_arbiter: RTL and testbench

- Shares one single-port pixel RAM between two requesters.
- Requester 1 is the scan-out fetch path that feeds the 640x480 timing/pattern generator. Requester 2 is a frame writer with a valid/ready interface.
- Manages double buffering: the display reads the front buffer, the writer fills the back buffer, and front/back swap only inside vertical sync.
- Sits between the timing generator (supplies blank, vsync) and the RAM.

---
 rtl/vga_fb_arbiter_if.sv | 40 ++++
 rtl/vga_fb_arbiter.sv | 112 +++++++++++
 tb/tb_vga_fb_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_arbiter_if.sv
// Bus bundle between the frame-buffer arbiter, the display path, the frame writer and the pixel RAM.
// "slave" is the arbiter's view and "master" is the surrounding system's view.
interface vga_fb_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 9
);
    logic          blank;
    logic          vsync;
    logic          disp_req;
    logic [AW-2:0] disp_addr;
    logic          disp_gnt;
    logic          disp_rvalid;
    logic [DW-1:0] disp_rdata;
    logic          wr_valid;
    logic [AW-2:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          swap_req;
    logic          swap_pending;
    logic          front_buf;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  blank, vsync, disp_req, disp_addr, wr_valid, wr_addr, wr_data,
               swap_req, mem_rdata,
        output disp_gnt, disp_rvalid, disp_rdata, wr_ready, swap_pending,
               front_buf, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output blank, vsync, disp_req, disp_addr, wr_valid, wr_addr, wr_data,
               swap_req, mem_rdata,
        input  disp_gnt, disp_rvalid, disp_rdata, wr_ready, swap_pending,
               front_buf, mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port pixel RAM arbiter: scan-out reads versus a frame writer,
// with double-buffer swaps taken only on the falling edge of vsync.
module vga_fb_arbiter #(
    parameter int AW           = 16,
    parameter int DW           = 9,
    parameter int STARVE_LIMIT = 15
) (
    input logic              clk,
    input logic              reset,
    vga_fb_arbiter_if.slave  bus
);
    localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

    logic          vsync_d_q;
    logic          vsync_fall;
    logic          swap_cycle;
    logic          starved;
    logic          disp_gnt_c;
    logic          wr_ready_c;
    logic [7:0]    starve_q, starve_d;
    logic          swap_pending_q, swap_pending_d;
    logic          front_q, front_d;
    logic          mem_en_q, mem_en_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          vld_p1_q, vld_p2_q;

    assign vsync_fall = vsync_d_q && !bus.vsync;
    assign swap_cycle = vsync_fall && swap_pending_q;
    assign starved    = bus.wr_valid && (starve_q == LIMIT);

    // Grants are combinational so a requester learns of acceptance in the same cycle.
    always_comb begin
        disp_gnt_c = 1'b0;
        wr_ready_c = 1'b0;
        if (!reset) begin
            if (swap_cycle) begin
                disp_gnt_c = bus.disp_req;
            end else if (bus.blank) begin
                wr_ready_c = bus.wr_valid;
                disp_gnt_c = bus.disp_req && !bus.wr_valid;
            end else begin
                wr_ready_c = bus.wr_valid && (!bus.disp_req || starved);
                disp_gnt_c = bus.disp_req && !wr_ready_c;
            end
        end
    end

    always_comb begin
        starve_d       = 8'd0;
        swap_pending_d = swap_pending_q;
        front_d        = front_q ^ swap_cycle;
        mem_en_d       = disp_gnt_c || wr_ready_c;
        mem_we_d       = wr_ready_c;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        if (bus.wr_valid && !wr_ready_c) begin
            starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 8'd1;
        end
        // A request arriving on the swap edge itself only arms the next frame.
        if (swap_cycle) begin
            swap_pending_d = 1'b0;
        end else if (bus.swap_req) begin
            swap_pending_d = 1'b1;
        end
        if (wr_ready_c) begin
            mem_addr_d  = {~front_q, bus.wr_addr};
            mem_wdata_d = bus.wr_data;
        end else if (disp_gnt_c) begin
            mem_addr_d  = {front_q, bus.disp_addr};
        end
    end

    // p0 -> p1: access registered onto the RAM port; p1 -> p2: read data returns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_d_q      <= 1'b1;
            starve_q       <= 8'd0;
            swap_pending_q <= 1'b0;
            front_q        <= 1'b0;
            mem_en_q       <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            vld_p1_q       <= 1'b0;
            vld_p2_q       <= 1'b0;
        end else begin
            vsync_d_q      <= bus.vsync;
            starve_q       <= starve_d;
            swap_pending_q <= swap_pending_d;
            front_q        <= front_d;
            mem_en_q       <= mem_en_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            vld_p1_q       <= disp_gnt_c;
            vld_p2_q       <= vld_p1_q;
        end
    end

    assign bus.disp_gnt     = disp_gnt_c;
    assign bus.wr_ready     = wr_ready_c;
    assign bus.disp_rvalid  = vld_p2_q;
    assign bus.disp_rdata   = bus.mem_rdata;
    assign bus.swap_pending = swap_pending_q;
    assign bus.front_buf    = front_q;
    assign bus.mem_en       = mem_en_q;
    assign bus.mem_we       = mem_we_q;
    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_wdata    = mem_wdata_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: read expectations are queued at grant time
// and retired against disp_rvalid/disp_rdata from a pattern-ROM RAM model.
module tb_vga_fb_arbiter;
    localparam int AW = 16;
    localparam int DW = 9;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vga_fb_arbiter_if #(.AW(AW), .DW(DW)) bus();

    vga_fb_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(15)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [DW-1:0] hash(input logic [AW-1:0] a);
        return a[8:0] ^ {a[15], a[14:7]};
    endfunction

    // RAM model: contents are a fixed function of the address.
    always @(posedge clk) begin
        if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= hash(bus.mem_addr);
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [AW-1:0] rdq[$];
    bit dg_prev = 1'b0;
    bit exp_fb  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle starting at posedge+1 with inputs already driven.
    task automatic step(input bit dg, input bit wr, input bit fb_nxt, input bit sp_nxt);
        logic [AW-1:0] ea;
        logic [AW-1:0] ra;
        logic [DW-1:0] wd;
        #3;
        chk("disp_gnt", bus.disp_gnt, dg);
        chk("wr_ready", bus.wr_ready, wr);
        ea = wr ? {~exp_fb, bus.wr_addr} : {exp_fb, bus.disp_addr};
        wd = bus.wr_data;
        if (dg) rdq.push_back(ea);
        @(posedge clk);
        #1;
        chk("mem_en", bus.mem_en, dg | wr);
        if (dg | wr) begin
            chk("mem_we", bus.mem_we, wr);
            chk("mem_addr", bus.mem_addr, ea);
        end
        if (wr) chk("mem_wdata", bus.mem_wdata, wd);
        chk("disp_rvalid", bus.disp_rvalid, dg_prev);
        if (bus.disp_rvalid) begin
            chk("rd_queue_nonempty", rdq.size() != 0, 1);
            if (rdq.size() != 0) begin
                ra = rdq.pop_front();
                chk("disp_rdata", bus.disp_rdata, hash(ra));
            end
        end
        chk("front_buf", bus.front_buf, fb_nxt);
        chk("swap_pending", bus.swap_pending, sp_nxt);
        dg_prev = dg;
        exp_fb  = fb_nxt;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_disp_gnt", bus.disp_gnt, 0);
        chk("rst_wr_ready", bus.wr_ready, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_disp_rvalid", bus.disp_rvalid, 0);
        chk("rst_swap_pending", bus.swap_pending, 0);
        chk("rst_front_buf", bus.front_buf, 0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.blank     = 1'b0;
        bus.vsync     = 1'b1;
        bus.disp_req  = 1'b1;
        bus.disp_addr = 15'h0055;
        bus.wr_valid  = 1'b1;
        bus.wr_addr   = 15'h0077;
        bus.wr_data   = 9'h0AA;
        bus.swap_req  = 1'b0;

        // Reset held while both requesters are asserting.
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        bus.disp_req = 1'b0;
        bus.wr_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) step(0, 0, 0, 0);

        // Active video, both requesting: 15 reads then one forced write.
        bus.blank    = 1'b0;
        bus.disp_req = 1'b1;
        bus.wr_valid = 1'b1;
        for (int k = 0; k < 32; k++) begin
            bus.disp_addr = 15'(k * 3 + 5);
            bus.wr_addr   = 15'(16'h0040 + k);
            bus.wr_data   = 9'(k * 7);
            step((k % 16) != 15, (k % 16) == 15, 0, 0);
        end

        // Address mapping with front_buf = 0.
        bus.wr_valid  = 1'b0;
        bus.disp_addr = 15'h0123;
        step(1, 0, 0, 0);
        bus.disp_req  = 1'b0;
        bus.wr_valid  = 1'b1;
        bus.wr_addr   = 15'h0123;
        bus.wr_data   = 9'h1A5;
        step(0, 1, 0, 0);

        // Blanking: writer owns the RAM; display resumes as blank falls.
        bus.blank    = 1'b1;
        bus.disp_req = 1'b1;
        bus.disp_addr = 15'h0200;
        for (int k = 0; k < 4; k++) begin
            bus.wr_addr = 15'(16'h0300 + k);
            bus.wr_data = 9'(k + 9'h100);
            step(0, 1, 0, 0);
        end
        bus.blank = 1'b0;
        step(1, 0, 0, 0);
        bus.disp_addr = 15'h0201;
        step(1, 0, 0, 0);
        bus.disp_req = 1'b0;
        bus.wr_valid = 1'b0;
        step(0, 0, 0, 0);

        // Swap armed, taken on the next vsync fall; writes blocked in that cycle.
        bus.blank    = 1'b1;
        bus.swap_req = 1'b1;
        step(0, 0, 0, 1);
        bus.swap_req = 1'b0;
        repeat (3) step(0, 0, 0, 1);
        bus.vsync    = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 15'h0010;
        bus.wr_data  = 9'h033;
        step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        bus.wr_valid = 1'b0;
        bus.vsync    = 1'b1;
        step(0, 0, 1, 0);
        bus.vsync    = 1'b0;
        step(0, 0, 1, 0);
        bus.blank     = 1'b0;
        bus.disp_req  = 1'b1;
        bus.disp_addr = 15'h0123;
        step(1, 0, 1, 0);

        // Reset with a read in flight: its rvalid must never appear.
        reset        = 1'b1;
        bus.disp_req = 1'b0;
        bus.vsync    = 1'b1;
        #1;
        chk_reset_outputs();
        @(posedge clk);
        #1;
        chk("rst_inflight_rvalid", bus.disp_rvalid, 0);
        reset   = 1'b0;
        dg_prev = 1'b0;
        exp_fb  = 1'b0;
        rdq.delete();
        step(0, 0, 0, 0);

        // swap_req coincident with a vsync fall only arms the following frame.
        bus.vsync    = 1'b0;
        bus.swap_req = 1'b1;
        step(0, 0, 0, 1);
        bus.swap_req = 1'b0;
        step(0, 0, 0, 1);
        bus.vsync = 1'b1;
        repeat (2) step(0, 0, 0, 1);
        bus.vsync    = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 15'h0456;
        bus.wr_data  = 9'h0F0;
        step(0, 0, 1, 0);
        step(0, 1, 1, 0);
        bus.wr_valid  = 1'b0;
        bus.disp_req  = 1'b1;
        bus.disp_addr = 15'h0042;
        step(1, 0, 1, 0);
        bus.disp_req = 1'b0;
        repeat (2) step(0, 0, 1, 0);
        chk("rd_queue_drained", rdq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
